// File: rtl/poly_voice_engine.sv
// Time-multiplexed polyphonic oscillator/mixer: per-voice phase accumulators scanned once
// per sample period through a 3-stage read / wave / multiply-accumulate pipeline.
module poly_voice_engine #(
    parameter int unsigned N_VOICES      = 8,
    parameter int unsigned IDX_W         = 8,
    parameter int unsigned PHASE_W       = 32,
    parameter int unsigned SAMPLE_W      = 24,
    parameter int unsigned SAMPLE_PERIOD = 1042
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_SPI_flag,
    input  logic                       i_SPI_note_status,
    input  logic [IDX_W-1:0]           i_SPI_voice_index,
    input  logic [PHASE_W-1:0]         i_SPI_tuning_code,
    input  logic [6:0]                 i_SPI_velocity,
    input  logic [1:0]                 i_wave_sel,
    output logic signed [SAMPLE_W-1:0] o_mixed_sample,
    output logic                       o_sample_valid,
    output logic [IDX_W:0]             o_active_count
);
    localparam int unsigned VIDX_W = (N_VOICES > 1) ? $clog2(N_VOICES) : 1;
    localparam int unsigned ACC_W  = 24 + $clog2(N_VOICES);
    localparam int unsigned CMP_W  = ((ACC_W > SAMPLE_W) ? ACC_W : SAMPLE_W) + 1;
    localparam int unsigned TICK_W = $clog2(SAMPLE_PERIOD);

    localparam logic [IDX_W:0]           N_LIM     = (IDX_W+1)'(N_VOICES);
    localparam logic [IDX_W:0]           CNT_ONE   = (IDX_W+1)'(1);
    localparam logic [TICK_W-1:0]        TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);
    localparam logic [TICK_W-1:0]        TICK_ONE  = TICK_W'(1);
    localparam logic [VIDX_W-1:0]        SCAN_LAST = VIDX_W'(N_VOICES - 1);
    localparam logic [VIDX_W-1:0]        SCAN_ONE  = VIDX_W'(1);
    localparam logic signed [CMP_W-1:0]  SAT_MAX   = CMP_W'((longint'(1) << (SAMPLE_W - 1)) - 1);
    localparam logic signed [CMP_W-1:0]  SAT_MIN   = ~SAT_MAX;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_OUT} state_t;

    state_t                     state_q, state_d;
    logic [TICK_W-1:0]          tick_q, tick_d;
    logic [VIDX_W-1:0]          scan_q, scan_d;
    logic                       drain_q, drain_d;
    logic [IDX_W:0]             count_q, count_d;

    logic                       gate_q  [N_VOICES];
    logic                       gate_d  [N_VOICES];
    logic [PHASE_W-1:0]         tune_q  [N_VOICES];
    logic [PHASE_W-1:0]         tune_d  [N_VOICES];
    logic [PHASE_W-1:0]         phase_q [N_VOICES];
    logic [PHASE_W-1:0]         phase_d [N_VOICES];
    logic [6:0]                 vel_q   [N_VOICES];
    logic [6:0]                 vel_d   [N_VOICES];

    logic                       s2_valid_q, s2_valid_d;
    logic [VIDX_W-1:0]          s2_idx_q, s2_idx_d;
    logic                       s2_gate_q, s2_gate_d;
    logic [PHASE_W-1:0]         s2_tune_q, s2_tune_d;
    logic [PHASE_W-1:0]         s2_phase_q, s2_phase_d;
    logic [6:0]                 s2_vel_q, s2_vel_d;
    logic                       s2_kill_q, s2_kill_d;

    logic                       s3_valid_q, s3_valid_d;
    logic signed [15:0]         s3_wave_q, s3_wave_d;
    logic [6:0]                 s3_vel_q, s3_vel_d;

    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic                       valid_q, valid_d;

    logic                       cmd_ok;
    logic [VIDX_W-1:0]          cmd_v;
    logic [15:0]                p;
    logic [15:0]                tri_u;
    logic signed [15:0]         wave;
    logic signed [7:0]          vel_s;
    logic signed [23:0]         prod;
    logic signed [CMP_W-1:0]    acc_ext;

    always_comb begin
        state_d    = state_q;
        tick_d     = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_ONE;
        scan_d     = scan_q;
        drain_d    = drain_q;
        count_d    = count_q;
        gate_d     = gate_q;
        tune_d     = tune_q;
        phase_d    = phase_q;
        vel_d      = vel_q;
        acc_d      = acc_q;
        sample_d   = sample_q;
        valid_d    = 1'b0;

        cmd_ok = i_SPI_flag && ({1'b0, i_SPI_voice_index} < N_LIM);
        cmd_v  = i_SPI_voice_index[VIDX_W-1:0];

        // Stage 3: velocity gain and accumulate
        vel_s = {1'b0, s3_vel_q};
        prod  = s3_wave_q * vel_s;
        if (s3_valid_q) begin
            acc_d = acc_q + ACC_W'(prod);
        end

        // Stage 2: waveform from the phase captured at stage 1, then advance it
        p     = s2_phase_q[PHASE_W-1 -: 16];
        tri_u = {p[14:0], 1'b0} ^ 16'h8000;
        case (i_wave_sel)
            2'd0:    wave = {~p[15], p[14:0]};
            2'd1:    wave = p[15] ? 16'sh8000 : 16'sh7FFF;
            2'd2:    wave = p[15] ? ~tri_u : tri_u;
            default: wave = '0;
        endcase
        s3_valid_d = s2_valid_q;
        s3_vel_d   = s2_vel_q;
        s3_wave_d  = s2_gate_q ? wave : '0;
        if (s2_valid_q && s2_gate_q && !s2_kill_q) begin
            phase_d[s2_idx_q] = s2_phase_q + s2_tune_q;
        end

        // Stage 1: capture voice state; a same-cycle command suppresses the later write-back
        s2_valid_d = (state_q == S_SCAN);
        s2_idx_d   = scan_q;
        s2_gate_d  = gate_q[scan_q];
        s2_tune_d  = tune_q[scan_q];
        s2_phase_d = phase_q[scan_q];
        s2_vel_d   = vel_q[scan_q];
        s2_kill_d  = cmd_ok && (cmd_v == scan_q);

        // Commands are applied last so they take priority over the scan write-back
        if (cmd_ok) begin
            if (i_SPI_note_status) begin
                gate_d[cmd_v]  = 1'b1;
                phase_d[cmd_v] = '0;
                tune_d[cmd_v]  = i_SPI_tuning_code;
                vel_d[cmd_v]   = i_SPI_velocity;
                if (!gate_q[cmd_v]) count_d = count_q + CNT_ONE;
            end else begin
                gate_d[cmd_v] = 1'b0;
                if (gate_q[cmd_v]) count_d = count_q - CNT_ONE;
            end
        end

        acc_ext = CMP_W'(acc_q);
        case (state_q)
            S_IDLE: begin
                if (tick_q == '0) begin
                    state_d = S_SCAN;
                    scan_d  = '0;
                    acc_d   = '0;
                end
            end
            S_SCAN: begin
                scan_d = scan_q + SCAN_ONE;
                if (scan_q == SCAN_LAST) begin
                    state_d = S_DRAIN;
                    drain_d = 1'b0;
                end
            end
            S_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) state_d = S_OUT;
            end
            default: begin
                if (acc_ext > SAT_MAX)      sample_d = SAT_MAX[SAMPLE_W-1:0];
                else if (acc_ext < SAT_MIN) sample_d = SAT_MIN[SAMPLE_W-1:0];
                else                        sample_d = acc_ext[SAMPLE_W-1:0];
                valid_d = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            tick_q     <= '0;
            scan_q     <= '0;
            drain_q    <= 1'b0;
            count_q    <= '0;
            gate_q     <= '{default: '0};
            tune_q     <= '{default: '0};
            phase_q    <= '{default: '0};
            vel_q      <= '{default: '0};
            s2_valid_q <= 1'b0;
            s2_idx_q   <= '0;
            s2_gate_q  <= 1'b0;
            s2_tune_q  <= '0;
            s2_phase_q <= '0;
            s2_vel_q   <= '0;
            s2_kill_q  <= 1'b0;
            s3_valid_q <= 1'b0;
            s3_wave_q  <= '0;
            s3_vel_q   <= '0;
            acc_q      <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            scan_q     <= scan_d;
            drain_q    <= drain_d;
            count_q    <= count_d;
            gate_q     <= gate_d;
            tune_q     <= tune_d;
            phase_q    <= phase_d;
            vel_q      <= vel_d;
            s2_valid_q <= s2_valid_d;
            s2_idx_q   <= s2_idx_d;
            s2_gate_q  <= s2_gate_d;
            s2_tune_q  <= s2_tune_d;
            s2_phase_q <= s2_phase_d;
            s2_vel_q   <= s2_vel_d;
            s2_kill_q  <= s2_kill_d;
            s3_valid_q <= s3_valid_d;
            s3_wave_q  <= s3_wave_d;
            s3_vel_q   <= s3_vel_d;
            acc_q      <= acc_d;
            sample_q   <= sample_d;
            valid_q    <= valid_d;
        end
    end

    assign o_mixed_sample = sample_q;
    assign o_sample_valid = valid_q;
    assign o_active_count = count_q;
endmodule

// File: tb/tb_poly_voice_engine.sv
// Directed bench for poly_voice_engine: a 4-voice/16-clock instance and a 256-voice/300-clock
// instance share one stimulus stream; expected samples go through a scoreboard queue.
module tb_poly_voice_engine;
    logic               clk;
    logic               rst;
    logic               flag;
    logic               note;
    logic [7:0]         idx;
    logic [31:0]        tune;
    logic [6:0]         vel;
    logic [1:0]         wsel;
    logic signed [23:0] sample_a, sample_b;
    logic               valid_a, valid_b;
    logic [8:0]         count_a, count_b;

    int     checks = 0;
    int     errors = 0;
    longint exp_q[$];

    poly_voice_engine #(.N_VOICES(4), .IDX_W(8), .PHASE_W(32), .SAMPLE_W(24), .SAMPLE_PERIOD(16)) dut_a (
        .i_clk(clk), .i_reset(rst), .i_SPI_flag(flag), .i_SPI_note_status(note),
        .i_SPI_voice_index(idx), .i_SPI_tuning_code(tune), .i_SPI_velocity(vel),
        .i_wave_sel(wsel), .o_mixed_sample(sample_a), .o_sample_valid(valid_a),
        .o_active_count(count_a)
    );

    poly_voice_engine #(.N_VOICES(256), .IDX_W(8), .PHASE_W(32), .SAMPLE_W(24), .SAMPLE_PERIOD(300)) dut_b (
        .i_clk(clk), .i_reset(rst), .i_SPI_flag(flag), .i_SPI_note_status(note),
        .i_SPI_voice_index(idx), .i_SPI_tuning_code(tune), .i_SPI_velocity(vel),
        .i_wave_sel(wsel), .o_mixed_sample(sample_b), .o_sample_valid(valid_b),
        .o_active_count(count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint wave(input int sel, input logic [31:0] ph);
        longint p;
        p = longint'(ph[31:16]);
        case (sel)
            0:       return p - 32768;
            1:       return (p < 32768) ? 32767 : -32768;
            2:       return (p < 32768) ? (2 * p - 32768) : (32767 - 2 * (p - 32768));
            default: return 0;
        endcase
    endfunction

    function automatic longint clamp(input longint x);
        if (x > 8388607)  return 8388607;
        if (x < -8388608) return -8388608;
        return x;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cmd(input bit on, input int v, input logic [31:0] t, input int ve);
        flag = 1'b1;
        note = on;
        idx  = 8'(v);
        tune = t;
        vel  = 7'(ve);
        tick();
        flag = 1'b0;
    endtask

    task automatic wait_valid(input bit which, input int limit, output int cyc);
        bit found;
        found = 1'b0;
        cyc   = 0;
        for (int i = 0; i < limit && !found; i++) begin
            tick();
            cyc++;
            if ((which ? valid_b : valid_a) === 1'b1) found = 1'b1;
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL valid_timeout: no pulse within %0d cycles, required one", limit);
        end
    endtask

    task automatic expect_sample(input bit which, input longint exp, input string tag, output int cyc);
        longint e;
        exp_q.push_back(exp);
        wait_valid(which, 700, cyc);
        e = exp_q.pop_front();
        chk(tag, which ? longint'(sample_b) : longint'(sample_a), e);
    endtask

    initial begin
        int cyc;
        int lat;
        rst = 1'b1; flag = 1'b0; note = 1'b0; idx = '0; tune = '0; vel = '0; wsel = 2'd0;
        repeat (3) tick();
        chk("reset_sample", longint'(sample_a), 0);
        chk("reset_valid", longint'(valid_a), 0);
        chk("reset_count", longint'(count_a), 0);
        rst = 1'b0;

        // Saw, single voice: latency from tick 0, then a 16-clock cadence
        wait_valid(1'b0, 40, cyc);
        chk("first_latency", cyc, 8);
        chk("empty_sample", longint'(sample_a), 0);
        cmd(1'b1, 1, 32'h1000_0000, 127);
        chk("count_one", longint'(count_a), 1);
        expect_sample(1'b0, 127 * wave(0, 32'h0000_0000), "saw_s0", cyc);
        expect_sample(1'b0, 127 * wave(0, 32'h1000_0000), "saw_s1", cyc);
        chk("period_16", cyc, 16);
        expect_sample(1'b0, 127 * wave(0, 32'h2000_0000), "saw_s2", cyc);
        tick();
        chk("valid_one_cycle", longint'(valid_a), 0);
        chk("sample_holds", longint'(sample_a), 127 * wave(0, 32'h2000_0000));

        // Square on all voices saturates; velocity 0 silences
        wsel = 2'd1;
        for (int v = 0; v < 4; v++) cmd(1'b1, v, 32'h0100_0000, 127);
        chk("count_four", longint'(count_a), 4);
        expect_sample(1'b0, clamp(4 * 127 * wave(1, 32'h0000_0000)), "square_clamp0", cyc);
        expect_sample(1'b0, clamp(4 * 127 * wave(1, 32'h0100_0000)), "square_clamp1", cyc);
        for (int v = 0; v < 4; v++) cmd(1'b1, v, 32'h0100_0000, 0);
        chk("count_retrigger", longint'(count_a), 4);
        expect_sample(1'b0, 0, "velocity_zero", cyc);

        // Triangle on voice 0 through all four quadrants
        wsel = 2'd2;
        cmd(1'b1, 0, 32'h4000_0000, 127);
        for (int k = 0; k < 4; k++) begin
            logic [31:0] ph;
            ph = 32'h4000_0000 * k;
            expect_sample(1'b0, 127 * wave(2, ph), $sformatf("tri_q%0d", k), cyc);
        end

        // Reset in the middle of a scan: aborted period, fresh latency afterwards
        repeat (10) tick();
        rst = 1'b1;
        tick();
        chk("midscan_sample", longint'(sample_a), 0);
        chk("midscan_valid", longint'(valid_a), 0);
        chk("midscan_count", longint'(count_a), 0);
        rst = 1'b0;
        wait_valid(1'b0, 40, cyc);
        chk("post_reset_latency", cyc, 8);
        chk("post_reset_sample", longint'(sample_a), 0);

        // Out-of-range index, double note-on, double note-off
        wsel = 2'd0;
        cmd(1'b1, 5, 32'h1000_0000, 127);
        chk("ignored_count", longint'(count_a), 0);
        expect_sample(1'b0, 0, "ignored_sample", cyc);
        cmd(1'b1, 1, 32'h0000_0000, 127);
        cmd(1'b1, 1, 32'h0000_0000, 127);
        chk("double_on_count", longint'(count_a), 1);
        expect_sample(1'b0, 127 * wave(0, 32'h0), "double_on_sample", cyc);
        cmd(1'b0, 1, 32'h0, 0);
        chk("off_count", longint'(count_a), 0);
        cmd(1'b0, 1, 32'h0, 0);
        chk("double_off_count", longint'(count_a), 0);
        expect_sample(1'b0, 0, "off_sample", cyc);

        // Collision: retrigger voice 2 on its own stage-1 cycle
        cmd(1'b1, 2, 32'h1000_0000, 50);
        expect_sample(1'b0, 50 * wave(0, 32'h0), "pre_collision", cyc);
        repeat (11) tick();
        cmd(1'b1, 2, 32'h2000_0000, 100);
        expect_sample(1'b0, 50 * wave(0, 32'h1000_0000), "collision_old", cyc);
        expect_sample(1'b0, 100 * wave(0, 32'h0), "collision_new0", cyc);
        expect_sample(1'b0, 100 * wave(0, 32'h2000_0000), "collision_new1", cyc);
        chk("collision_count", longint'(count_a), 1);

        // 256 voices, high indices on the large instance
        rst = 1'b1;
        tick();
        chk("big_reset_sample", longint'(sample_b), 0);
        chk("big_reset_count", longint'(count_b), 0);
        rst = 1'b0;
        cmd(1'b1, 252, 32'd20000000, 100);
        cmd(1'b1, 253, 32'd20000000, 100);
        chk("big_count", longint'(count_b), 2);
        chk("small_ignores_high", longint'(count_a), 0);
        expect_sample(1'b1, clamp(2 * 100 * wave(0, 32'd0)), "big_s0", cyc);
        lat = cyc + 2;
        chk("big_latency", lat, 260);
        expect_sample(1'b1, clamp(2 * 100 * wave(0, 32'd20000000)), "big_s1", cyc);
        chk("big_period", cyc, 300);
        chk("small_silent", longint'(sample_a), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/poly_voice_engine.md
Name: poly_voice_engine

Overview:
- Parametrised, time-multiplexed polyphonic oscillator and mixer; successor to the fixed-size voice controller.
- Holds per-voice tuning, velocity, gate and phase for N_VOICES voices, all loaded from the SPI command decoder.
- Once per audio sample period it scans every voice in turn: oscillator, velocity gain, accumulate.
- Produces one saturated signed sample for the DAC offset stage, with a valid strobe.

Parameters:
N_VOICES, 8, number of voices (1..256)
IDX_W, 8, width of voice index port
PHASE_W, 32, phase accumulator / tuning word width
SAMPLE_W, 24, output sample width
SAMPLE_PERIOD, 1042, clocks per output sample; must be >= N_VOICES+4

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_SPI_flag  in  1  one-cycle command strobe
i_SPI_note_status  in  1  1 = note-on, 0 = note-off
i_SPI_voice_index  in  IDX_W  target voice
i_SPI_tuning_code  in  PHASE_W  phase increment per sample
i_SPI_velocity  in  7  velocity 0..127
i_wave_sel  in  2  0 saw, 1 square, 2 triangle, 3 mute
o_mixed_sample  out  SAMPLE_W  signed mixed sample
o_sample_valid  out  1  one-cycle pulse when o_mixed_sample updates
o_active_count  out  IDX_W+1  number of gated voices

Behaviour:
- Reset: all gates 0, phases 0, tunings 0, velocities 0, tick counter 0, FSM IDLE. o_mixed_sample=0, o_sample_valid=0, o_active_count=0.
- Commands are accepted every cycle i_SPI_flag=1, and are ignored if index >= N_VOICES.
  - Note-on: gate=1, phase=0, tuning and velocity latched.
  - Note-off: gate=0; tuning, velocity and phase retained.
  - Note-on to an already-gated voice retriggers it: phase=0, new tuning and velocity.
- o_active_count updates the cycle after a command. It counts gates set, so repeated note-on or note-off does not double-count.
- Tick counter counts 0..SAMPLE_PERIOD-1 and wraps. At count 0 the FSM leaves IDLE.
- FSM states:
  - IDLE -> SCAN: clear the accumulator.
  - SCAN: one voice per clock, v=0..N_VOICES-1.
  - DRAIN: 2 cycles of pipeline flush.
  - OUT: saturate, register the output, pulse o_sample_valid.
  - OUT -> IDLE.
- Scan pipeline:
  - Stage 1: read voice v.
  - Stage 2: compute wave from the current phase, then phase += tuning (mod 2^PHASE_W), only if gate=1.
  - Stage 3: product = wave * {0,velocity}, 16s x 8s -> 24s. Accumulate into ACC_W = 24+clog2(N_VOICES) bits.
- Ungated voices contribute 0 and their phase is frozen.
- Waveforms, with p = phase[PHASE_W-1 -: 16]:
  - saw = {~p[15], p[14:0]} as signed.
  - square = +32767 if p[15]=0, else -32768.
  - triangle = signed fold of p: rising -32768..+32767 over the first half, falling over the second.
  - mute = 0; phases still advance.
- OUT clamps the accumulator to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
- o_sample_valid is high exactly N_VOICES+4 cycles after tick=0, for one cycle. o_mixed_sample holds between pulses.
- Command collision: a command to voice v in the same cycle as stage 1 reads voice v.
  - The scan uses the old values.
  - The command wins: the register ends with the command's values, and the scan's phase write-back to that voice is suppressed.
- i_wave_sel is sampled per voice at stage 2; a mid-scan change affects only the remaining voices.
- Reset mid-scan aborts the scan: no o_sample_valid pulse, all state to reset values.

Test Plan:
1. N_VOICES=4, SAMPLE_PERIOD=16, saw; note-on voice 1, tuning 0x1000_0000, velocity 127 -> samples -4161536, -3641344, -3121152, …; o_sample_valid every 16 clocks, 8 clocks after tick 0; o_active_count=1.
2. Square, all 4 voices note-on, velocity 127, tuning 0x0100_0000 -> raw sum 16645636 clamps to 8388607. Then velocity 0 on all -> 0.
3. Index 5 (N_VOICES=4) note-on -> ignored, o_active_count=0, output 0. Then note-on voice 1 twice -> count 1; note-off voice 1 -> count 0, output 0 from next sample.
4. Collision: note-on voice 2 issued on the stage-1 cycle for voice 2 -> that sample's voice 2 contribution uses the old state (0 if previously ungated); the next sample uses phase 0 and the new velocity.
5. Assert i_reset mid-SCAN -> no o_sample_valid that period; all outputs 0; the next period outputs 0 until a new note-on.
6. N_VOICES=256, SAMPLE_PERIOD=300, voices 252 and 253 note-on, tuning 20000000, velocity 100, saw -> first sample -6553600; valid pulse at tick+260.
